// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/immediate/result-select encodings, NOP.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

endpackage

// File: rtl/decode_stage_reg_file.sv
// 2-read/1-write register file with x0 hardwired to zero and synchronous clear.
// Optional write-through to the read ports when DECODE_RF_BYPASS_EN is defined.
module reg_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [AW-1:0]   i_raddr1,
    input  logic [AW-1:0]   i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREGS];
    logic            w_wr_en;

    assign w_wr_en = i_we && (i_waddr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
        o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
`ifdef DECODE_RF_BYPASS_EN
        if (w_wr_en && (i_waddr == i_raddr1)) o_rdata1 = i_wdata;
        if (w_wr_en && (i_waddr == i_raddr2)) o_rdata2 = i_wdata;
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, control decode and immediate extension.
// Define DECODE_RF_BYPASS_EN for same-cycle writeback forwarding in the register file.
module decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned   XLEN      = 32,
    parameter int unsigned   NREGS     = 32,
    parameter logic [31:0]   NOP_INSTR = rv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            RegWriteW,
    input  logic [4:0]      RdW,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] RD1D,
    output logic [XLEN-1:0] RD2D,
    output logic [XLEN-1:0] ImmExtD,
    output logic [4:0]      Rs1D,
    output logic [4:0]      Rs2D,
    output logic [4:0]      RdD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            RegWriteD,
    output logic            MemWriteD,
    output logic            JumpD,
    output logic            BranchD,
    output logic            ALUSrcD,
    output logic [1:0]      ResultSrcD,
    output logic [2:0]      ALUControlD,
    output logic            IllegalD
);

    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pc4;

    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_pc4   <= '0;
        end else if (!StallD) begin
            r_instr <= InstrF;
            r_pc    <= PCF;
            r_pc4   <= PCPlus4F;
        end
    end

    assign PCD      = r_pc;
    assign PCPlus4D = r_pc4;
    assign Rs1D     = r_instr[19:15];
    assign Rs2D     = r_instr[24:20];
    assign RdD      = r_instr[11:7];

    reg_file #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .i_we     (RegWriteW),
        .i_waddr  (RdW),
        .i_wdata  (ResultW),
        .i_raddr1 (r_instr[19:15]),
        .i_raddr2 (r_instr[24:20]),
        .o_rdata1 (RD1D),
        .o_rdata2 (RD2D)
    );

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    imm_src_t    w_imm_src;
    result_src_t w_res_src;
    alu_op_t     w_alu_op;
    logic        w_alu_arith;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7b5 = r_instr[30];

    always_comb begin
        RegWriteD   = 1'b0;
        ALUSrcD     = 1'b0;
        MemWriteD   = 1'b0;
        BranchD     = 1'b0;
        JumpD       = 1'b0;
        IllegalD    = 1'b0;
        w_res_src   = RES_ALU;
        w_imm_src   = IMM_I;
        w_alu_arith = 1'b0;
        unique case (w_opcode)
            OP_LOAD: begin
                RegWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                w_res_src = RES_MEM;
            end
            OP_STORE: begin
                ALUSrcD   = 1'b1;
                MemWriteD = 1'b1;
                w_imm_src = IMM_S;
            end
            OP_R: begin
                RegWriteD   = 1'b1;
                w_alu_arith = 1'b1;
            end
            OP_I: begin
                RegWriteD   = 1'b1;
                ALUSrcD     = 1'b1;
                w_alu_arith = 1'b1;
            end
            OP_BRANCH: begin
                BranchD   = 1'b1;
                w_imm_src = IMM_B;
            end
            OP_JAL: begin
                RegWriteD = 1'b1;
                JumpD     = 1'b1;
                w_res_src = RES_PC4;
                w_imm_src = IMM_J;
            end
            OP_JALR: begin
                RegWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                JumpD     = 1'b1;
                w_res_src = RES_PC4;
            end
            OP_LUI: begin
                RegWriteD = 1'b1;
                ALUSrcD   = 1'b1;
                w_imm_src = IMM_U;
            end
            default: IllegalD = 1'b1;
        endcase
    end

    // funct7[5] only distinguishes sub from add on register-register ops
    always_comb begin
        w_alu_op = ALU_ADD;
        if (w_alu_arith) begin
            unique case (w_funct3)
                3'b000:  w_alu_op = (w_opcode == OP_R && w_funct7b5) ? ALU_SUB : ALU_ADD;
                3'b001:  w_alu_op = ALU_SLL;
                3'b010:  w_alu_op = ALU_SLT;
                3'b100:  w_alu_op = ALU_XOR;
                3'b101:  w_alu_op = ALU_SRL;
                3'b110:  w_alu_op = ALU_OR;
                3'b111:  w_alu_op = ALU_AND;
                default: w_alu_op = ALU_ADD;
            endcase
        end else if (w_opcode == OP_BRANCH) begin
            w_alu_op = ALU_SUB;
        end
    end

    always_comb begin
        unique case (w_imm_src)
            IMM_S:   ImmExtD = XLEN'($signed({r_instr[31:25], r_instr[11:7]}));
            IMM_B:   ImmExtD = XLEN'($signed({r_instr[31], r_instr[7], r_instr[30:25],
                                               r_instr[11:8], 1'b0}));
            IMM_J:   ImmExtD = XLEN'($signed({r_instr[31], r_instr[19:12], r_instr[20],
                                               r_instr[30:21], 1'b0}));
            IMM_U:   ImmExtD = XLEN'($signed({r_instr[31:12], 12'b0}));
            default: ImmExtD = XLEN'($signed(r_instr[31:20]));
        endcase
    end

    assign ResultSrcD  = w_res_src;
    assign ALUControlD = w_alu_op;

endmodule
